// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bundle for clk_div_ctrl.
//   cfg_valid : new half-period offered (master -> slave)
//   cfg_half  : requested half-period in clk_in cycles (master -> slave)
//   cfg_ready : controller can accept a config this cycle (slave -> master)
//   cfg_err   : one-cycle pulse, accepted config was zero and discarded (slave -> master)
interface clk_div_ctrl_if #(
    parameter int unsigned DIV_W = 8
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_half,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_half,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider controller.
// Produces a glitch-free divided clock and a tick enable from clk_in. The
// divide ratio changes and stops are deferred to period boundaries, so
// clk_out never shows a runt pulse.
//   clk_in   : system clock
//   reset    : asynchronous, active-high reset
//   enable   : level-sensitive run request
//   cfg      : config handshake (slave side of clk_div_ctrl_if)
//   clk_out  : divided clock, registered
//   tick     : one-cycle pulse coincident with each clk_out rise
//   busy     : controller is in RUN or STOP
//   cur_half : half-period currently in effect
module clk_div_ctrl #(
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned DEFAULT_HALF = 32,
    parameter bit          TEST_MODE    = 1'b0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    clk_div_ctrl_if.slave    cfg,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [DIV_W-1:0] cur_half
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] pend;
    logic             pend_v;

    logic [DIV_W-1:0] heff_c;
    logic             last_c;
    logic             xfer_c;
    logic             cfg_zero_c;
    logic             fall_c;
    logic             drop_c;
    logic             apply_c;

    // Effective half-period and end-of-half-period detect.
    assign heff_c     = TEST_MODE ? DIV_W'(1) : cur_half;
    assign last_c     = (cnt == (heff_c - DIV_W'(1)));

    assign xfer_c     = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_zero_c = (cfg.cfg_half == '0);

    // Falling toggle of clk_out: the only boundary where a pending ratio lands.
    assign fall_c     = (state != IDLE) && clk_out && last_c;
    // Stop request while low: leave at once, nothing partial is emitted.
    assign drop_c     = (state == RUN) && !enable && !clk_out;
    // A pending value is applied at the falling toggle or whenever IDLE is
    // reached/occupied with it still outstanding.
    assign apply_c    = pend_v && (fall_c || drop_c || (state == IDLE));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            pend          <= '0;
            pend_v        <= 1'b0;
            clk_out       <= 1'b0;
            tick          <= 1'b0;
            busy          <= 1'b0;
            cur_half      <= DIV_W'(DEFAULT_HALF);
            cfg.cfg_ready <= 1'b1;
            cfg.cfg_err   <= 1'b0;
        end else begin
            tick        <= 1'b0;
            cfg.cfg_err <= xfer_c && cfg_zero_c;

            // Divider sequencing.
            case (state)
                IDLE: begin
                    clk_out <= 1'b0;
                    cnt     <= '0;
                    if (enable) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (drop_c) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (last_c) begin
                        cnt     <= '0;
                        clk_out <= !clk_out;
                        tick    <= !clk_out;
                        // Here clk_out is high whenever enable is low, so this
                        // is the falling toggle and the period is complete.
                        if (!enable) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                        if (!enable) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (last_c) begin
                        cnt     <= '0;
                        clk_out <= 1'b0;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cnt     <= '0;
                    clk_out <= 1'b0;
                end
            endcase

            // Config handshake; apply and transfer are exclusive because a
            // transfer needs cfg_ready, which is low while pend_v is set.
            if (apply_c) begin
                cur_half      <= pend;
                pend_v        <= 1'b0;
                cfg.cfg_ready <= 1'b1;
            end else if (xfer_c && !cfg_zero_c) begin
                if (state == IDLE) begin
                    cur_half <= cfg.cfg_half;
                end else begin
                    pend          <= cfg.cfg_half;
                    pend_v        <= 1'b1;
                    cfg.cfg_ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl.
// dut0 runs with the reset ratio of 32; dut1 has TEST_MODE set.
module tb_clk_div_ctrl;

    localparam int unsigned DIV_W = 8;

    logic             clk;
    logic             rst;
    logic             en0;
    logic             en1;
    logic             co0, tk0, bz0;
    logic             co1, tk1, bz1;
    logic [DIV_W-1:0] ch0, ch1;

    int tests;
    int fails;

    clk_div_ctrl_if #(.DIV_W(DIV_W)) if0 ();
    clk_div_ctrl_if #(.DIV_W(DIV_W)) if1 ();

    clk_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_HALF(32), .TEST_MODE(1'b0)) dut0 (
        .clk_in   (clk),
        .reset    (rst),
        .enable   (en0),
        .cfg      (if0),
        .clk_out  (co0),
        .tick     (tk0),
        .busy     (bz0),
        .cur_half (ch0)
    );

    clk_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_HALF(32), .TEST_MODE(1'b1)) dut1 (
        .clk_in   (clk),
        .reset    (rst),
        .enable   (en1),
        .cfg      (if1),
        .clk_out  (co1),
        .tick     (tk1),
        .busy     (bz1),
        .cur_half (ch1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clk_in edge, then settle before sampling/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        if0.cfg_valid = 1'b0;
        if0.cfg_half  = '0;
        if1.cfg_valid = 1'b0;
        if1.cfg_half  = '0;
        step();
        step();
        rst = 1'b0;
        step();
        tests++; if (co0 !== 1'b0) begin fails++; $display("FAIL reset_clk_out: got %0b expected 0", co0); end
        tests++; if (tk0 !== 1'b0) begin fails++; $display("FAIL reset_tick: got %0b expected 0", tk0); end
        tests++; if (bz0 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", bz0); end
        tests++; if (ch0 !== 8'd32) begin fails++; $display("FAIL reset_cur_half: got %0d expected 32", ch0); end
        tests++; if (if0.cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready: got %0b expected 1", if0.cfg_ready); end
        tests++; if (if0.cfg_err !== 1'b0) begin fails++; $display("FAIL reset_cfg_err: got %0b expected 0", if0.cfg_err); end
    endtask

    // Half 32: first rise 32 cycles after RUN entry, 64-cycle period.
    task automatic test_default();
        int ticks;
        ticks = 0;
        en0 = 1'b1;
        for (int n = 1; n <= 97; n++) begin
            step();
            if (tk0 === 1'b1) ticks++;
            if (n == 1) begin
                tests++; if (bz0 !== 1'b1) begin fails++; $display("FAIL def_busy: got %0b expected 1", bz0); end
            end
            if (n == 32) begin
                tests++; if (co0 !== 1'b0) begin fails++; $display("FAIL def_pre_rise: got %0b expected 0", co0); end
            end
            if (n == 33) begin
                tests++; if (co0 !== 1'b1) begin fails++; $display("FAIL def_rise: got %0b expected 1", co0); end
                tests++; if (tk0 !== 1'b1) begin fails++; $display("FAIL def_tick: got %0b expected 1", tk0); end
            end
            if (n == 34) begin
                tests++; if (tk0 !== 1'b0) begin fails++; $display("FAIL def_tick_width: got %0b expected 0", tk0); end
            end
            if (n == 64) begin
                tests++; if (co0 !== 1'b1) begin fails++; $display("FAIL def_high_end: got %0b expected 1", co0); end
            end
            if (n == 65) begin
                tests++; if (co0 !== 1'b0) begin fails++; $display("FAIL def_fall: got %0b expected 0", co0); end
            end
            if (n == 97) begin
                tests++; if (co0 !== 1'b1 || tk0 !== 1'b1) begin fails++; $display("FAIL def_second_rise: got clk_out=%0b tick=%0b expected 1/1", co0, tk0); end
            end
        end
        tests++; if (ticks != 2) begin fails++; $display("FAIL def_tick_count: got %0d expected 2", ticks); end
    endtask

    // Enable dropped right after a rise: full 32-cycle high phase, then IDLE.
    task automatic test_stop_high();
        int ticks;
        ticks = 0;
        en0 = 1'b0;
        for (int m = 1; m <= 32; m++) begin
            step();
            if (tk0 === 1'b1) ticks++;
            if (m == 1) begin
                tests++; if (bz0 !== 1'b1 || co0 !== 1'b1) begin fails++; $display("FAIL stop_hi_start: got busy=%0b clk_out=%0b expected 1/1", bz0, co0); end
            end
            if (m == 31) begin
                tests++; if (co0 !== 1'b1) begin fails++; $display("FAIL stop_hi_hold: got %0b expected 1", co0); end
            end
            if (m == 32) begin
                tests++; if (co0 !== 1'b0 || bz0 !== 1'b0) begin fails++; $display("FAIL stop_hi_end: got clk_out=%0b busy=%0b expected 0/0", co0, bz0); end
            end
        end
        tests++; if (ticks != 0) begin fails++; $display("FAIL stop_hi_ticks: got %0d expected 0", ticks); end
    endtask

    // Half 3 programmed in IDLE: 3 high / 3 low, tick every 6.
    task automatic test_cfg_idle();
        if0.cfg_valid = 1'b1;
        if0.cfg_half  = 8'd3;
        step();
        if0.cfg_valid = 1'b0;
        tests++; if (ch0 !== 8'd3) begin fails++; $display("FAIL idle_cfg: got %0d expected 3", ch0); end
        en0 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (n == 3) begin
                tests++; if (co0 !== 1'b0) begin fails++; $display("FAIL h3_pre_rise: got %0b expected 0", co0); end
            end
            if (n == 4) begin
                tests++; if (co0 !== 1'b1 || tk0 !== 1'b1) begin fails++; $display("FAIL h3_rise: got clk_out=%0b tick=%0b expected 1/1", co0, tk0); end
            end
            if (n == 5) begin
                tests++; if (tk0 !== 1'b0) begin fails++; $display("FAIL h3_tick_width: got %0b expected 0", tk0); end
            end
            if (n == 6) begin
                tests++; if (co0 !== 1'b1) begin fails++; $display("FAIL h3_high_end: got %0b expected 1", co0); end
            end
            if (n == 7) begin
                tests++; if (co0 !== 1'b0) begin fails++; $display("FAIL h3_fall: got %0b expected 0", co0); end
            end
            if (n == 10) begin
                tests++; if (co0 !== 1'b1 || tk0 !== 1'b1) begin fails++; $display("FAIL h3_rise2: got clk_out=%0b tick=%0b expected 1/1", co0, tk0); end
            end
        end
    endtask

    // Half 5 offered mid-high: current high stays 3, later halves are 5.
    task automatic test_cfg_run();
        step();
        tests++; if (if0.cfg_ready !== 1'b1) begin fails++; $display("FAIL run_ready_pre: got %0b expected 1", if0.cfg_ready); end
        if0.cfg_valid = 1'b1;
        if0.cfg_half  = 8'd5;
        step();
        if0.cfg_valid = 1'b0;
        tests++; if (if0.cfg_ready !== 1'b0) begin fails++; $display("FAIL run_ready_drop: got %0b expected 0", if0.cfg_ready); end
        tests++; if (ch0 !== 8'd3 || co0 !== 1'b1) begin fails++; $display("FAIL run_pend_hold: got cur_half=%0d clk_out=%0b expected 3/1", ch0, co0); end
        step();
        tests++; if (co0 !== 1'b0 || ch0 !== 8'd5) begin fails++; $display("FAIL run_apply: got clk_out=%0b cur_half=%0d expected 0/5", co0, ch0); end
        tests++; if (if0.cfg_ready !== 1'b1) begin fails++; $display("FAIL run_ready_back: got %0b expected 1", if0.cfg_ready); end
        for (int n = 14; n <= 23; n++) begin
            step();
            if (n == 17) begin
                tests++; if (co0 !== 1'b0) begin fails++; $display("FAIL h5_low_end: got %0b expected 0", co0); end
            end
            if (n == 18) begin
                tests++; if (co0 !== 1'b1 || tk0 !== 1'b1) begin fails++; $display("FAIL h5_rise: got clk_out=%0b tick=%0b expected 1/1", co0, tk0); end
            end
            if (n == 22) begin
                tests++; if (co0 !== 1'b1) begin fails++; $display("FAIL h5_high_end: got %0b expected 1", co0); end
            end
            if (n == 23) begin
                tests++; if (co0 !== 1'b0) begin fails++; $display("FAIL h5_fall: got %0b expected 0", co0); end
            end
        end
    endtask

    // Enable dropped during low phase: IDLE next cycle, no high pulse.
    task automatic test_stop_low();
        int highs;
        highs = 0;
        step();
        en0 = 1'b0;
        step();
        tests++; if (bz0 !== 1'b0 || co0 !== 1'b0) begin fails++; $display("FAIL stop_lo: got busy=%0b clk_out=%0b expected 0/0", bz0, co0); end
        for (int i = 0; i < 8; i++) begin
            step();
            if (co0 === 1'b1 || tk0 === 1'b1) highs++;
        end
        tests++; if (highs != 0) begin fails++; $display("FAIL stop_lo_pulse: got %0d high cycles expected 0", highs); end
    endtask

    // Zero half-period: discarded with a one-cycle error pulse.
    task automatic test_cfg_err();
        if0.cfg_valid = 1'b1;
        if0.cfg_half  = 8'd0;
        step();
        if0.cfg_valid = 1'b0;
        tests++; if (if0.cfg_err !== 1'b1) begin fails++; $display("FAIL err_pulse: got %0b expected 1", if0.cfg_err); end
        tests++; if (ch0 !== 8'd5) begin fails++; $display("FAIL err_keep: got %0d expected 5", ch0); end
        step();
        tests++; if (if0.cfg_err !== 1'b0) begin fails++; $display("FAIL err_width: got %0b expected 0", if0.cfg_err); end
    endtask

    // TEST_MODE: clk_out toggles every cycle whatever cur_half reports.
    task automatic test_test_mode();
        if1.cfg_valid = 1'b1;
        if1.cfg_half  = 8'd7;
        step();
        if1.cfg_valid = 1'b0;
        tests++; if (ch1 !== 8'd7) begin fails++; $display("FAIL tm_cur_half: got %0d expected 7", ch1); end
        en1 = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step();
            if (n == 1) begin
                tests++; if (bz1 !== 1'b1 || co1 !== 1'b0) begin fails++; $display("FAIL tm_enter: got busy=%0b clk_out=%0b expected 1/0", bz1, co1); end
            end
            if (n == 2) begin
                tests++; if (co1 !== 1'b1 || tk1 !== 1'b1) begin fails++; $display("FAIL tm_rise: got clk_out=%0b tick=%0b expected 1/1", co1, tk1); end
            end
            if (n == 3) begin
                tests++; if (co1 !== 1'b0 || tk1 !== 1'b0) begin fails++; $display("FAIL tm_fall: got clk_out=%0b tick=%0b expected 0/0", co1, tk1); end
            end
            if (n == 4) begin
                tests++; if (co1 !== 1'b1 || tk1 !== 1'b1) begin fails++; $display("FAIL tm_rise2: got clk_out=%0b tick=%0b expected 1/1", co1, tk1); end
            end
        end
        en1 = 1'b0;
        step();
        step();
    endtask

    // Asynchronous reset in a high phase clears outputs before any edge.
    task automatic test_async_reset();
        en0 = 1'b1;
        for (int n = 1; n <= 7; n++) step();
        tests++; if (co0 !== 1'b1 || bz0 !== 1'b1) begin fails++; $display("FAIL ar_pre: got clk_out=%0b busy=%0b expected 1/1", co0, bz0); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (co0 !== 1'b0) begin fails++; $display("FAIL ar_clk_out: got %0b expected 0", co0); end
        tests++; if (bz0 !== 1'b0) begin fails++; $display("FAIL ar_busy: got %0b expected 0", bz0); end
        tests++; if (ch0 !== 8'd32) begin fails++; $display("FAIL ar_cur_half: got %0d expected 32", ch0); end
        en0 = 1'b0;
        step();
        rst = 1'b0;
        step();
        tests++; if (bz0 !== 1'b0 || co0 !== 1'b0) begin fails++; $display("FAIL ar_after: got busy=%0b clk_out=%0b expected 0/0", bz0, co0); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_default();
        test_stop_high();
        test_cfg_idle();
        test_cfg_run();
        test_stop_low();
        test_cfg_err();
        test_test_mode();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
